// File: rtl/rv_pkg.sv
// RV32I field constants shared by the instruction encoder and decoder.
// Combinational constants and helpers only; no latency and no flow control.
// Flow control does not apply here.
package rv_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADDI = 3'b000;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } enc_state_e;

    // True when v[31:lsb] are all copies of one bit, i.e. v fits a signed field.
    function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] s;
        s = $signed(v) >>> lsb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/rv_enc_pack.sv
// Packs RV32I fields into one instruction word by format and range-checks the immediate.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module rv_enc_pack
    import rv_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] inst_o,
    output logic        range_ok_o
);

    always_comb begin
        inst_o     = '0;
        range_ok_o = 1'b0;
        case (fmt_i)
            FMT_R: begin
                inst_o     = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                range_ok_o = 1'b1;
            end
            FMT_I: begin
                inst_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                range_ok_o = upper_uniform(imm_i, 11);
            end
            FMT_S: begin
                inst_o     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                range_ok_o = upper_uniform(imm_i, 11);
            end
            FMT_B: begin
                inst_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                              imm_i[4:1], imm_i[11], opcode_i};
                range_ok_o = upper_uniform(imm_i, 12) && !imm_i[0];
            end
            FMT_U: begin
                inst_o     = {imm_i[31:12], rd_i, opcode_i};
                range_ok_o = (imm_i[11:0] == 12'd0);
            end
            FMT_J: begin
                inst_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                range_ok_o = upper_uniform(imm_i, 20) && !imm_i[0];
            end
            default: begin
                // Codes 6/7 are illegal and always rejected.
                inst_o     = '0;
                range_ok_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_enc.sv
// Sequential RV32I encoder: field requests in, 32-bit words out, li expanded to LUI+ADDI.
// Latency: accept in cycle N, word (or err pulse) in N+1; li second word in N+2.
// Backpressure: one-entry output register held while out_ready low; req_ready low in EXPAND.
module rv_enc
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_fmt,
    input  logic [6:0]  req_opcode,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [31:0] req_imm,
    input  logic        req_li,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        err
);

    enc_state_e  state_q;
    logic        out_valid_q;
    logic [31:0] out_inst_q;
    logic        out_last_q;
    logic        err_q;
    logic [31:0] pend_q;

    logic [31:0] pack_inst;
    logic        pack_ok;

    logic        accept;
    logic        take;
    logic        li_fits;
    logic [19:0] li_hi;
    logic [31:0] li_addi_x0;
    logic [31:0] li_addi_rd;
    logic [31:0] li_lui;

    rv_enc_pack u_pack (
        .fmt_i      (req_fmt),
        .opcode_i   (req_opcode),
        .rd_i       (req_rd),
        .rs1_i      (req_rs1),
        .rs2_i      (req_rs2),
        .funct3_i   (req_funct3),
        .funct7_i   (req_funct7),
        .imm_i      (req_imm),
        .inst_o     (pack_inst),
        .range_ok_o (pack_ok)
    );

    assign take      = out_valid_q && out_ready;
    assign req_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = req_valid && req_ready;

    // Rounding the upper part by imm[11] compensates for ADDI sign-extending its low 12 bits.
    assign li_fits    = upper_uniform(req_imm, 11);
    assign li_hi      = req_imm[31:12] + {19'd0, req_imm[11]};
    assign li_lui     = {li_hi, req_rd, OP_LUI};
    assign li_addi_x0 = {req_imm[11:0], 5'd0, F3_ADDI, req_rd, OP_OPIMM};
    assign li_addi_rd = {req_imm[11:0], req_rd, F3_ADDI, req_rd, OP_OPIMM};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= '0;
        end else begin
            err_q <= 1'b0;
            if (take) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_li) begin
                            out_valid_q <= 1'b1;
                            if (li_fits) begin
                                out_inst_q <= li_addi_x0;
                                out_last_q <= 1'b1;
                            end else if (req_imm[11:0] == 12'd0) begin
                                out_inst_q <= li_lui;
                                out_last_q <= 1'b1;
                            end else begin
                                out_inst_q <= li_lui;
                                out_last_q <= 1'b0;
                                pend_q     <= li_addi_rd;
                                state_q    <= ST_EXPAND;
                            end
                        end else if (pack_ok) begin
                            out_valid_q <= 1'b1;
                            out_inst_q  <= pack_inst;
                            out_last_q  <= 1'b1;
                        end else begin
                            // Rejected request is consumed; any old word was taken this cycle.
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_EXPAND: begin
                    if (take) begin
                        out_valid_q <= 1'b1;
                        out_inst_q  <= pend_q;
                        out_last_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule
